// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter driving a shared decoder2to4 (sel/en),
// with a registered one-hot grant copy, hold-limit timeout and a break-before-make gap.
module rr_arbiter4 #(
    parameter int HOLD_MAX = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       en,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state, state_d;
    logic [1:0]       ptr, ptr_d;
    logic [1:0]       sel_d;
    logic [1:0]       winner;
    logic             found;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             en_d;
    logic             timeout_d;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit add wraps mod 4.
    always_comb begin
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
                found  = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state;
        ptr_d     = ptr;
        cnt_d     = cnt;
        sel_d     = sel;
        en_d      = 1'b0;
        timeout_d = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    en_d    = 1'b1;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!req[sel]) begin
                    state_d = GAP;
                    ptr_d   = sel + 2'd1;
                end else if (cnt == CNT_LAST) begin
                    state_d   = GAP;
                    timeout_d = 1'b1;
                    ptr_d     = sel + 2'd1;
                end else begin
                    en_d  = 1'b1;
                    cnt_d = cnt + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            cnt     <= '0;
            sel     <= 2'd0;
            en      <= 1'b0;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            state   <= state_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
            sel     <= sel_d;
            en      <= en_d;
            // Built from the same next values as en/sel so gnt never shows a stale index.
            gnt     <= en_d ? (4'b0001 << sel_d) : 4'b0000;
            busy    <= (state_d != IDLE);
            timeout <= timeout_d;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4: vector table, hand-written timeout/reset
// sequences, and randomized requests against a behavioural reference model.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 15;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic       en;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int tests  = 0;
    int failed = 0;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .sel     (sel),
        .en      (en),
        .gnt     (gnt),
        .busy    (busy),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (got running, required done)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Waits for the next grant with req held constant; reports low cycles counted
    // before it, the granted index, its length and whether timeout fired at its end.
    task automatic wait_grant(input string name, output int lo, output int gsel,
                              output int hlen, output logic tpulse);
        lo = 0; gsel = 0; hlen = 0; tpulse = 1'b0;
        while (en !== 1'b1 && lo < 60) begin
            tick();
            lo++;
        end
        if (en !== 1'b1) begin
            check({name, "_grant_wait"}, 32'(en), 32'd1);
            return;
        end
        gsel = int'(sel);
        while (en === 1'b1 && hlen < 60) begin
            hlen++;
            tick();
        end
        tpulse = timeout;
    endtask

    // Behavioural model: tracks who owns the resource and for how many cycles.
    int m_phase;   // 0 = free, 1 = granted, 2 = gap
    int m_owner;
    int m_held;
    int m_ptr;
    logic m_to;

    task automatic model_reset();
        m_phase = 0; m_owner = 0; m_held = 0; m_ptr = 0; m_to = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        m_to = 1'b0;
        if (m_phase == 0) begin
            for (int i = 0; i < 4; i++) begin
                if (m_phase == 0 && r[(m_ptr + i) % 4]) begin
                    m_owner = (m_ptr + i) % 4;
                    m_held  = 1;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (!r[m_owner]) begin
                m_phase = 2;
                m_ptr   = (m_owner + 1) % 4;
            end else if (m_held == HOLD_MAX) begin
                m_phase = 2;
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % 4;
            end else begin
                m_held++;
            end
        end else begin
            m_phase = 0;
        end
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [1:0] sel;
        logic       en;
        logic [3:0] gnt;
        logic       busy;
        logic       to;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic [3:0] q, input logic [1:0] s,
                       input logic e, input logic [3:0] g, input logic b, input logic t);
        vec_t v;
        v.rst = r; v.req = q; v.sel = s; v.en = e; v.gnt = g; v.busy = b; v.to = t;
        vq.push_back(v);
    endtask

    initial begin
        int lo, gs, hl;
        logic tp;

        rst = 1'b1;
        req = 4'b0000;

        // Reset with all requests high, then idle.
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
        add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);
        // Single request from agent 2 for three cycles.
        add(0, 4'b0100, 2, 1, 4'b0100, 1, 0);
        add(0, 4'b0100, 2, 1, 4'b0100, 1, 0);
        add(0, 4'b0100, 2, 1, 4'b0100, 1, 0);
        add(0, 4'b0000, 2, 0, 4'b0000, 1, 0);
        add(0, 4'b0000, 2, 0, 4'b0000, 0, 0);
        add(1, 4'b0000, 0, 0, 4'b0000, 0, 0);
        // Fairness: all request, each owner drops two cycles after its grant.
        add(0, 4'b1111, 0, 1, 4'b0001, 1, 0);
        add(0, 4'b1111, 0, 1, 4'b0001, 1, 0);
        add(0, 4'b1110, 0, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 0, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 1, 1, 4'b0010, 1, 0);
        add(0, 4'b1111, 1, 1, 4'b0010, 1, 0);
        add(0, 4'b1101, 1, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 2, 1, 4'b0100, 1, 0);
        add(0, 4'b1111, 2, 1, 4'b0100, 1, 0);
        add(0, 4'b1011, 2, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 2, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 3, 1, 4'b1000, 1, 0);
        add(0, 4'b1111, 3, 1, 4'b1000, 1, 0);
        add(0, 4'b0111, 3, 0, 4'b0000, 1, 0);
        add(0, 4'b1111, 3, 0, 4'b0000, 0, 0);
        add(0, 4'b1111, 0, 1, 4'b0001, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 1, 0);
        add(0, 4'b0000, 0, 0, 4'b0000, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst;
            req = vq[i].req;
            tick();
            check($sformatf("vec%0d_sel", i),     32'(sel),     32'(vq[i].sel));
            check($sformatf("vec%0d_en", i),      32'(en),      32'(vq[i].en));
            check($sformatf("vec%0d_gnt", i),     32'(gnt),     32'(vq[i].gnt));
            check($sformatf("vec%0d_busy", i),    32'(busy),    32'(vq[i].busy));
            check($sformatf("vec%0d_timeout", i), 32'(timeout), 32'(vq[i].to));
        end

        // Single agent held: grant lasts HOLD_MAX cycles, then re-grant after the gap.
        do_reset();
        req = 4'b0001;
        wait_grant("solo1", lo, gs, hl, tp);
        check("solo_sel", 32'(gs), 32'd0);
        check("solo_len", 32'(hl), 32'(HOLD_MAX));
        check("solo_pulse", 32'(tp), 32'd1);
        tick();
        check("solo_pulse_end", 32'(timeout), 32'd0);
        check("solo_gap_en", 32'(en), 32'd0);
        wait_grant("solo2", lo, gs, hl, tp);
        // One more low cycle after the two already observed above.
        check("solo_regap", 32'(lo), 32'd1);
        check("solo_resel", 32'(gs), 32'd0);

        // Two competitors held: 0 times out, 1 wins, then 0 again.
        do_reset();
        req = 4'b0011;
        wait_grant("comp1", lo, gs, hl, tp);
        check("comp1_sel", 32'(gs), 32'd0);
        check("comp1_len", 32'(hl), 32'(HOLD_MAX));
        check("comp1_pulse", 32'(tp), 32'd1);
        wait_grant("comp2", lo, gs, hl, tp);
        check("comp2_gap", 32'(lo), 32'd2);
        check("comp2_sel", 32'(gs), 32'd1);
        check("comp2_len", 32'(hl), 32'(HOLD_MAX));
        check("comp2_pulse", 32'(tp), 32'd1);
        wait_grant("comp3", lo, gs, hl, tp);
        check("comp3_sel", 32'(gs), 32'd0);

        // Reset mid-grant clears outputs without a clock edge and restores ptr=0.
        do_reset();
        req = 4'b1000;
        tick();
        check("rmid_gnt", 32'(gnt), 32'b1000);
        #2 rst = 1'b1;
        #1;
        check("rmid_en_async", 32'(en), 32'd0);
        check("rmid_gnt_async", 32'(gnt), 32'd0);
        check("rmid_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        req = 4'b1001;
        tick();
        check("rmid_sel_after", 32'(sel), 32'd0);
        check("rmid_gnt_after", 32'(gnt), 32'b0001);

        // Randomized requests against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 11) == 0) req = 4'($urandom);
            @(posedge clk);
            if (rst) model_reset();
            else model_step(req);
            #1;
            check($sformatf("rnd%0d_en", c),      32'(en),   32'(m_phase == 1));
            check($sformatf("rnd%0d_busy", c),    32'(busy), 32'(m_phase != 0));
            check($sformatf("rnd%0d_sel", c),     32'(sel),  32'(m_owner));
            check($sformatf("rnd%0d_gnt", c),     32'(gnt),
                  (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
            check($sformatf("rnd%0d_timeout", c), 32'(timeout), 32'(m_to));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one decoder2to4 instance between four agents. It drives the decoder's `in`/`enable` pair, so the decoder output becomes a one-hot grant bus. It also emits a registered copy of that one-hot grant for local use. Each grant is held until the owner drops its request or a hold limit expires, and a one-cycle break-before-make gap separates consecutive grants.

## Interface
Parameters:
- `HOLD_MAX`, default 15: maximum consecutive cycles one grant may stay asserted; legal range 1..(2^CNT_W − 1).
- `CNT_W`, default 4: width of the hold counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `req`  input  4  request per agent; level-sensitive, held high while the agent wants the resource.
- `sel`  output  2  index of the granted agent; drives decoder2to4 `in`.
- `en`  output  1  grant valid; drives decoder2to4 `enable`.
- `gnt`  output  4  registered one-hot grant; equals `en ? (4'b0001 << sel) : 4'b0000`.
- `busy`  output  1  high whenever the FSM is not in IDLE.
- `timeout`  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- All outputs are registered. Reset values: `sel`=0, `en`=0, `gnt`=0, `busy`=0, `timeout`=0. Internal state resets to IDLE, `ptr`=0, `cnt`=0.
- Priority order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first agent in that order with `req` high wins.
- FSM states:
  - IDLE: if `req`≠0, latch the winner into `sel`, set `en`=1, clear `cnt`, and go to GRANT. Otherwise stay, with `en`=0.
  - GRANT: `en` stays 1 and `sel` is frozen. The FSM samples `req[sel]` and `cnt` each edge, and the first matching rule applies:
    1. If `req[sel]`=0: go to GAP with `en`=0 and `ptr`=sel+1 (mod 4). This is a normal release.
    2. Else if `cnt`==HOLD_MAX−1: go to GAP with `en`=0, `timeout`=1 for that one cycle, and `ptr`=sel+1. This is a forced release.
    3. Else: `cnt`=cnt+1.
  - GAP: `en`=0 for exactly one cycle, then go to IDLE unconditionally.
- Requests from other agents during GRANT have no effect; there is no preemption.
- A timed-out agent whose `req` is still high becomes lowest priority and is re-granted only when no other agent requests.
- `sel` holds its last value when `en`=0.
- `cnt` never exceeds HOLD_MAX−1, so there is no wrap.
- Asserting `rst` mid-grant drops `en`/`gnt` immediately (asynchronous) and clears `ptr`.

## Timing
- Request-to-grant latency: `req` rises before edge N while in IDLE; `en`/`gnt` are high after edge N (1 cycle).
- Release latency: `req[sel]` falls before edge M; `en` is low after edge M.
- Maximum grant width is exactly HOLD_MAX cycles of `en`=1.
- Minimum spacing between two grants is 2 cycles of `en`=0: one GAP cycle plus one IDLE evaluation cycle.
- A request stream from one agent yields 1 cycle held plus a 2-cycle-low pattern at best.
- `timeout` rises on the same edge that `en` falls and lasts one cycle.
- `busy` is high from the edge entering GRANT through the GAP cycle.
- `gnt` always changes on the same edge as `en`/`sel`, never with a stale index.

## Test plan
- Reset/idle: hold `rst`=1 with `req`=4'b1111, then release with `req`=0. `en`=0, `gnt`=0, `busy`=0, `timeout`=0 throughout.
- Single request: `req`=4'b0100 for 3 cycles, then 0. `sel`=2 and `gnt`=4'b0100 appear 1 cycle after the request, stay for 3 cycles, then `en`=0 and `busy` falls after GAP.
- Round-robin fairness: `req`=4'b1111, with each agent dropping its request 2 cycles after being granted and re-raising it. Grants go to 0, 1, 2, 3, 0 in order, separated by 2-cycle gaps.
- Timeout (HOLD_MAX=15): `req`=4'b0001 held constant. `en` stays high exactly 15 cycles, `timeout` pulses once when `en` falls, and agent 0 is re-granted after 2 idle cycles.
- Timeout with a competitor: `req`=4'b0011 held constant. Agent 0 times out, agent 1 is granted next, and after agent 1's timeout agent 0 is granted.
- Reset mid-grant: assert `rst` while `gnt`=4'b1000. `en`/`gnt` go to 0 without waiting for a clock edge. After release with `req`=4'b1001, agent 0 wins because `ptr`=0.
